// File: rtl/memory_access_sequencer.sv
// Sequences MEM-stage loads/stores onto a synchronous single-port RAM: word store 2 cycles, load 3, sub-word store 4 (read-merge-write), fault 1.
// Holds the pipeline via stall until the RESP cycle; SIGNED_LOAD_EN enables sign extension of sub-word loads.
module memory_access_sequencer #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  stall,
  output logic                  done,
  output logic                  rdata_valid,
  output logic [31:0]           rdata,
  output logic                  misaligned,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  state_t                state_q, state_d;
  logic                  write_q, write_d;
  logic [1:0]            size_q, size_d;
  logic                  signed_q, signed_d;
  logic                  fault_q, fault_d;
  logic [ADDR_WIDTH+1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           merged_q, merged_d;
  logic [31:0]           rdata_q, rdata_d;

  logic        req_word, req_half, req_mis;
  logic        word_q, byte_q;
  logic        ext_sign;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_val, merge_val;
  logic        unused_bits;

  assign req_word = (req_size == 2'd0) || (req_size == 2'd3);
  assign req_half = (req_size == 2'd1);
  assign req_mis  = (req_half && req_addr[0]) || (req_word && (req_addr[1:0] != 2'b00));

  assign word_q = (size_q == 2'd0) || (size_q == 2'd3);
  assign byte_q = (size_q == 2'd2);

`ifdef SIGNED_LOAD_EN
  assign ext_sign    = signed_q;
  assign unused_bits = ^req_addr[31:ADDR_WIDTH+2];
`else
  assign ext_sign    = 1'b0;
  assign unused_bits = ^{req_addr[31:ADDR_WIDTH+2], signed_q};
`endif

  assign byte_lane = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign half_lane = mem_rdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    load_val = mem_rdata;
    if (byte_q) begin
      load_val = {{24{ext_sign & byte_lane[7]}}, byte_lane};
    end else if (!word_q) begin
      load_val = {{16{ext_sign & half_lane[15]}}, half_lane};
    end
  end

  // Only the addressed lane is replaced; the rest of the word comes from the read.
  always_comb begin
    merge_val = mem_rdata;
    if (byte_q) begin
      merge_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      fault_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      merged_q <= 32'd0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      fault_q  <= fault_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merged_q <= merged_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    signed_d    = signed_q;
    fault_d     = fault_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    merged_d    = merged_q;
    rdata_d     = rdata_q;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    done        = 1'b0;
    rdata_valid = 1'b0;
    misaligned  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr[ADDR_WIDTH+1:0];
          wdata_d  = req_wdata;
          fault_d  = req_mis;
          if (req_mis)                    state_d = RESP;
          else if (req_write && req_word) state_d = WR;
          else                            state_d = RD;
        end
      end
      RD: begin
        mem_en  = 1'b1;
        state_d = CAP;
      end
      CAP: begin
        if (write_q) begin
          merged_d = merge_val;
          state_d  = WR;
        end else begin
          rdata_d  = load_val;
          state_d  = RESP;
        end
      end
      WR: begin
        mem_en  = 1'b1;
        mem_we  = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        done        = 1'b1;
        rdata_valid = !write_q && !fault_q;
        misaligned  = fault_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Gated by reset_n so stall reads 0 while reset is held, whatever req_valid does.
  assign stall     = reset_n && req_valid && (state_q != RESP);
  assign mem_addr  = addr_q[ADDR_WIDTH+1:2];
  assign mem_wdata = word_q ? wdata_q : merged_q;
  assign rdata     = rdata_q;

endmodule
